// File: rtl/nexys_starship_monster_bank_if.sv
// Bus bundle for the monster bank: game controls and per-lane spawn/kill
// requests in, lane status, danger warnings, score and game state out.
interface nexys_starship_monster_bank_if #(
    parameter int NUM_LANES = 4,
    parameter int SCORE_W   = 8
);
    logic                 tick;
    logic                 play_flag;
    logic [NUM_LANES-1:0] spawn_req;
    logic [NUM_LANES-1:0] shoot;
    logic [NUM_LANES-1:0] monster_on;
    logic [NUM_LANES-1:0] danger;
    logic                 game_over;
    logic [SCORE_W-1:0]   score;
    logic                 q_Init;
    logic                 q_Play;
    logic                 q_Over;

    // Game logic side (random generator, shooter, display consumers).
    modport master (
        output tick, play_flag, spawn_req, shoot,
        input  monster_on, danger, game_over, score, q_Init, q_Play, q_Over
    );

    // Monster bank side.
    modport slave (
        input  tick, play_flag, spawn_req, shoot,
        output monster_on, danger, game_over, score, q_Init, q_Play, q_Over
    );
endinterface

// File: rtl/nexys_starship_monster_bank.sv
// Multi-lane monster controller: NUM_LANES independent EMPTY/FULL slots with
// survival timers, a shared INIT/PLAY/OVER game FSM and a saturating score.
//
// Game states:
//   state   | meaning
//   INIT    | lanes held empty, waiting for play_flag to start
//   PLAY    | lanes spawn, get shot and age on tick
//   OVER    | a lane expired; lanes cleared, score frozen until play_flag drops
module nexys_starship_monster_bank #(
    parameter int NUM_LANES = 4,
    parameter int TIMER_W   = 8,
    parameter int TIMEOUT   = 100,
    parameter int WARN      = 75,
    parameter int SCORE_W   = 8
) (
    input logic Clk,
    input logic Reset,
    nexys_starship_monster_bank_if.slave bus
);

    typedef enum logic [2:0] {
        ST_INIT = 3'b001,
        ST_PLAY = 3'b010,
        ST_OVER = 3'b100
    } game_state_t;

    localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(TIMEOUT);
    localparam logic [TIMER_W-1:0] WARN_VAL    = TIMER_W'(WARN);
    localparam int CNT_W = $clog2(NUM_LANES + 1);
    localparam int SUM_W = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    game_state_t          state_q, state_d;
    logic [NUM_LANES-1:0] full_q, full_d;
    logic [TIMER_W-1:0]   timer_q [NUM_LANES];
    logic [TIMER_W-1:0]   timer_d [NUM_LANES];
    logic [NUM_LANES-1:0] danger_q, danger_d;
    logic [NUM_LANES-1:0] expire;
    logic [NUM_LANES-1:0] kill;
    logic                 any_expire;
    logic [CNT_W-1:0]     kill_cnt;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 game_over_q;

    // Expiry detect: a resident monster whose timer has reached TIMEOUT.
    always_comb begin
        expire = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            expire[i] = full_q[i] && (timer_q[i] == TIMEOUT_VAL);
        end
        any_expire = (state_q == ST_PLAY) && (|expire);
    end

    // Game FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (bus.play_flag) state_d = ST_PLAY;
            ST_PLAY: if (any_expire)    state_d = ST_OVER;
            ST_OVER: if (!bus.play_flag) state_d = ST_INIT;
            default: state_d = ST_INIT;
        endcase
    end

    // Lane next state: expiry beats shoot beats spawn; only PLAY lets lanes live.
    always_comb begin
        full_d = '0;
        kill   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            timer_d[i] = '0;
        end
        if (state_q == ST_PLAY && !any_expire) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (full_q[i]) begin
                    if (bus.shoot[i]) begin
                        kill[i] = 1'b1;
                    end else begin
                        full_d[i]  = 1'b1;
                        timer_d[i] = timer_q[i];
                        if (bus.tick && timer_q[i] != TIMEOUT_VAL) begin
                            timer_d[i] = timer_q[i] + TIMER_W'(1);
                        end
                    end
                end else if (bus.spawn_req[i]) begin
                    full_d[i] = 1'b1;
                end
            end
        end
    end

    // Danger is derived from next-state values so it lines up with the timer.
    always_comb begin
        danger_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            danger_d[i] = full_d[i] && (timer_d[i] >= WARN_VAL);
        end
    end

    // Score update: cleared on game start, saturating add of this edge's kills.
    // An expiry edge freezes the score entirely, including kills in other lanes.
    always_comb begin
        kill_cnt  = CNT_W'($countones(kill));
        score_sum = SUM_W'(score_q) + SUM_W'(kill_cnt);
        score_d   = score_q;
        if (state_q == ST_INIT && bus.play_flag) begin
            score_d = '0;
        end else if (state_q == ST_PLAY && !any_expire) begin
            if (score_sum > SUM_W'(SCORE_MAX)) begin
                score_d = SCORE_MAX;
            end else begin
                score_d = score_sum[SCORE_W-1:0];
            end
        end
    end

    // State, lane, timer and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_INIT;
            full_q      <= '0;
            danger_q    <= '0;
            score_q     <= '0;
            game_over_q <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                timer_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            danger_q    <= danger_d;
            score_q     <= score_d;
            game_over_q <= (state_d == ST_OVER);
            for (int i = 0; i < NUM_LANES; i++) begin
                timer_q[i] <= timer_d[i];
            end
        end
    end

    assign bus.monster_on = full_q;
    assign bus.danger     = danger_q;
    assign bus.game_over  = game_over_q;
    assign bus.score      = score_q;
    assign bus.q_Init     = (state_q == ST_INIT);
    assign bus.q_Play     = (state_q == ST_PLAY);
    assign bus.q_Over     = (state_q == ST_OVER);

endmodule

// File: tb/tb_nexys_starship_monster_bank.sv
// Scoreboard bench for the monster bank. Two instances with different
// parameters share one stimulus stream; a behavioural game model predicts the
// outputs after each edge and a monitor compares them.
module tb_nexys_starship_monster_bank;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    always #5 Clk = ~Clk;

    nexys_starship_monster_bank_if #(.NUM_LANES(4), .SCORE_W(4)) bus_a ();
    nexys_starship_monster_bank_if #(.NUM_LANES(4), .SCORE_W(2)) bus_b ();

    nexys_starship_monster_bank #(
        .NUM_LANES(4), .TIMER_W(8), .TIMEOUT(5), .WARN(3), .SCORE_W(4)
    ) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(bus_a)
    );

    nexys_starship_monster_bank #(
        .NUM_LANES(4), .TIMER_W(2), .TIMEOUT(3), .WARN(2), .SCORE_W(2)
    ) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(bus_b)
    );

    typedef struct {
        int   inst;
        int   mon;
        int   dan;
        int   go;
        int   score;
        int   q;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    // Model parameters and state, one entry per instance.
    int p_to[2]   = '{5, 3};
    int p_warn[2] = '{3, 2};
    int p_smax[2] = '{15, 3};
    int m_st[2];               // 0 = INIT, 1 = PLAY, 2 = OVER
    bit m_full[2][4];
    int m_tmr[2][4];
    int m_sc[2];

    bit       in_rst, in_play, in_tick;
    bit [3:0] in_spawn, in_shoot;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void clear_lanes(input int k);
        for (int i = 0; i < 4; i++) begin
            m_full[k][i] = 1'b0;
            m_tmr[k][i]  = 0;
        end
    endfunction

    function automatic void model_step(input int k);
        int kills;
        bit expired;
        if (in_rst) begin
            m_st[k] = 0;
            m_sc[k] = 0;
            clear_lanes(k);
            return;
        end
        case (m_st[k])
            0: begin
                clear_lanes(k);
                if (in_play) begin
                    m_st[k] = 1;
                    m_sc[k] = 0;
                end
            end
            1: begin
                expired = 1'b0;
                for (int i = 0; i < 4; i++)
                    if (m_full[k][i] && m_tmr[k][i] == p_to[k]) expired = 1'b1;
                if (expired) begin
                    m_st[k] = 2;
                    clear_lanes(k);
                end else begin
                    kills = 0;
                    for (int i = 0; i < 4; i++) begin
                        if (m_full[k][i]) begin
                            if (in_shoot[i]) begin
                                m_full[k][i] = 1'b0;
                                m_tmr[k][i]  = 0;
                                kills++;
                            end else if (in_tick && m_tmr[k][i] < p_to[k]) begin
                                m_tmr[k][i]++;
                            end
                        end else if (in_spawn[i]) begin
                            m_full[k][i] = 1'b1;
                            m_tmr[k][i]  = 0;
                        end
                    end
                    m_sc[k] = (m_sc[k] + kills > p_smax[k]) ? p_smax[k] : m_sc[k] + kills;
                end
            end
            default: begin
                clear_lanes(k);
                if (!in_play) m_st[k] = 0;
            end
        endcase
    endfunction

    function automatic exp_t model_out(input int k);
        exp_t e;
        e.inst = k;
        e.mon = 0;
        e.dan = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_full[k][i]) e.mon += (1 << i);
            if (m_full[k][i] && m_tmr[k][i] >= p_warn[k]) e.dan += (1 << i);
        end
        e.go    = (m_st[k] == 2) ? 1 : 0;
        e.score = m_sc[k];
        e.q     = (m_st[k] == 0) ? 1 : (m_st[k] == 1) ? 2 : 4;
        return e;
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue the prediction.
    task automatic step(input bit r, input bit p, input bit t,
                        input bit [3:0] sp, input bit [3:0] sh);
        @(negedge Clk);
        in_rst = r; in_play = p; in_tick = t; in_spawn = sp; in_shoot = sh;
        Reset = r;
        bus_a.play_flag = p; bus_a.tick = t; bus_a.spawn_req = sp; bus_a.shoot = sh;
        bus_b.play_flag = p; bus_b.tick = t; bus_b.spawn_req = sp; bus_b.shoot = sh;
        for (int k = 0; k < 2; k++) begin
            model_step(k);
            sbq.push_back(model_out(k));
        end
    endtask

    // Monitor: after every rising edge compare all pending predictions.
    initial begin
        exp_t e;
        int a_mon, a_dan, a_go, a_sc, a_q;
        forever begin
            @(posedge Clk);
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.inst == 0) begin
                    a_mon = int'(bus_a.monster_on); a_dan = int'(bus_a.danger);
                    a_go = int'(bus_a.game_over); a_sc = int'(bus_a.score);
                    a_q = int'({bus_a.q_Over, bus_a.q_Play, bus_a.q_Init});
                end else begin
                    a_mon = int'(bus_b.monster_on); a_dan = int'(bus_b.danger);
                    a_go = int'(bus_b.game_over); a_sc = int'(bus_b.score);
                    a_q = int'({bus_b.q_Over, bus_b.q_Play, bus_b.q_Init});
                end
                chk($sformatf("inst%0d monster_on", e.inst), a_mon, e.mon);
                chk($sformatf("inst%0d danger", e.inst), a_dan, e.dan);
                chk($sformatf("inst%0d game_over", e.inst), a_go, e.go);
                chk($sformatf("inst%0d score", e.inst), a_sc, e.score);
                chk($sformatf("inst%0d state_onehot", e.inst), a_q, e.q);
            end
        end
    end

    initial begin
        bit p;
        bus_a.play_flag = 0; bus_a.tick = 0; bus_a.spawn_req = '0; bus_a.shoot = '0;
        bus_b.play_flag = 0; bus_b.tick = 0; bus_b.spawn_req = '0; bus_b.shoot = '0;

        step(1, 0, 0, 4'b0000, 4'b0000);
        step(1, 0, 0, 4'b0000, 4'b0000);
        step(0, 0, 0, 4'b0000, 4'b0000);

        // Start, single spawn on lane 1, then kill it.
        step(0, 1, 0, 4'b0010, 4'b0000);
        step(0, 1, 0, 4'b0010, 4'b0000);
        step(0, 1, 0, 4'b0000, 4'b0000);
        step(0, 1, 0, 4'b0000, 4'b0010);
        // Shooting an empty lane does nothing.
        step(0, 1, 0, 4'b0000, 4'b0100);

        // All four lanes full, simultaneous kill: score 1 -> 5 (B saturates at 3).
        step(0, 1, 0, 4'b1111, 4'b0000);
        step(0, 1, 0, 4'b1111, 4'b0000);
        step(0, 1, 0, 4'b0000, 4'b1111);

        // Lanes 0 and 2 full with score 5, then reset mid-play.
        step(0, 1, 1, 4'b0101, 4'b0000);
        step(0, 1, 0, 4'b0000, 4'b0000);
        step(1, 1, 0, 4'b0000, 4'b0000);
        step(0, 0, 0, 4'b0000, 4'b0000);

        // Lane 3 ages with one tick every 4 cycles until each instance expires.
        step(0, 1, 0, 4'b0000, 4'b0000);
        step(0, 1, 0, 4'b1000, 4'b0000);
        for (int c = 0; c < 30; c++) step(0, 1, (c % 4) == 3, 4'b0000, 4'b0000);

        // In OVER with play held high: spawns ignored, stay OVER.
        for (int c = 0; c < 3; c++) step(0, 1, 1, 4'b1111, 4'b1111);
        step(0, 0, 0, 4'b0000, 4'b0000);
        step(0, 0, 0, 4'b0000, 4'b0000);
        step(0, 1, 0, 4'b0000, 4'b0000);

        // Timer at TIMEOUT for B (3) while shot: B ends with no score, A kills.
        step(0, 1, 0, 4'b1000, 4'b0000);
        for (int c = 0; c < 3; c++) step(0, 1, 1, 4'b0000, 4'b0000);
        step(0, 1, 0, 4'b0000, 4'b1000);
        step(0, 0, 0, 4'b0000, 4'b0000);
        step(0, 1, 0, 4'b0000, 4'b0000);

        // Repeated full-board kills to saturate both scores.
        for (int r = 0; r < 5; r++) begin
            step(0, 1, 0, 4'b1111, 4'b0000);
            step(0, 1, 0, 4'b0000, 4'b1111);
        end

        // Randomised play.
        p = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            bit [3:0] sp, sh;
            if ($urandom_range(0, 39) == 0) p = ~p;
            for (int i = 0; i < 4; i++) begin
                sp[i] = ($urandom_range(0, 3) == 0);
                sh[i] = ($urandom_range(0, 5) == 0);
            end
            step($urandom_range(0, 199) == 0, p, $urandom_range(0, 2) == 0, sp, sh);
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
